tetris_vga_renderer: RTL and testbench

- Read side of the game's 10x20 board state.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Snapshots the locked-cell board and the active-piece overlay once per frame, at vertical-blank start, so game logic may update freely mid-frame.
- Emits the frame_start tick that drives game timing (GAME_SPEED counts frames) and renders cells, border and background to 8-bit RGB.

---
 rtl/tetris_vga_renderer.sv | 197 +++++++++++++++++++
 tb/tb_tetris_vga_renderer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_vga_renderer.sv
// 640x480@60 VGA scan-out of a 10x20 board; board/piece snapshotted once per frame at vblank start.
// Colour and syncs lag the counters by 2 pixel ticks; board_valid is only sampled on the frame_start clk.
module tetris_vga_renderer #(
   parameter int X_ORIGIN  = 220,
   parameter int Y_ORIGIN  = 40,
   parameter int CELL_PX   = 20,
   parameter int BORDER_PX = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [199:0] board_in,
   input  logic [199:0] piece_in,
   input  logic         board_valid,
   output logic         board_ack,
   output logic         frame_start,
   output logic         vga_HS,
   output logic         vga_VS,
   output logic [7:0]   R,
   output logic [7:0]   G,
   output logic [7:0]   B
);

   localparam logic [9:0] H_VIS      = 10'd640;
   localparam logic [9:0] H_SYNC_BEG = 10'd656;
   localparam logic [9:0] H_SYNC_END = 10'd752;
   localparam logic [9:0] H_LAST     = 10'd799;
   localparam logic [9:0] V_VIS      = 10'd480;
   localparam logic [9:0] V_SYNC_BEG = 10'd490;
   localparam logic [9:0] V_SYNC_END = 10'd492;
   localparam logic [9:0] V_LAST     = 10'd524;

   localparam logic [9:0] PF_X0 = 10'(X_ORIGIN);
   localparam logic [9:0] PF_X1 = 10'(X_ORIGIN + 10 * CELL_PX);
   localparam logic [9:0] PF_Y0 = 10'(Y_ORIGIN);
   localparam logic [9:0] PF_Y1 = 10'(Y_ORIGIN + 20 * CELL_PX);
   localparam logic [9:0] BD_X0 = 10'(X_ORIGIN - BORDER_PX);
   localparam logic [9:0] BD_X1 = 10'(X_ORIGIN + 10 * CELL_PX + BORDER_PX);
   localparam logic [9:0] BD_Y0 = 10'(Y_ORIGIN - BORDER_PX);
   localparam logic [9:0] BD_Y1 = 10'(Y_ORIGIN + 20 * CELL_PX + BORDER_PX);
   localparam logic [4:0] SUB_LAST = 5'(CELL_PX - 1);

   localparam logic [1:0] RG_OUT    = 2'd0;
   localparam logic [1:0] RG_BORDER = 2'd1;
   localparam logic [1:0] RG_PLAY   = 2'd2;

   logic         pix_en;
   logic [9:0]   h_cnt, v_cnt, h_nxt, v_nxt;
   logic         h_wrap;
   logic [4:0]   x_sub, y_sub;
   logic [3:0]   col;
   logic [4:0]   row;
   logic         snap_evt;
   logic [199:0] board_snap, piece_snap;
   logic         in_vis, in_pf, in_bd;
   logic [1:0]   region;
   logic         raw_hs, raw_vs;
   logic [1:0]   s1_region;
   logic [3:0]   s1_col;
   logic [4:0]   s1_row;
   logic         s1_hs, s1_vs;
   logic [7:0]   cell_lin, bit_idx;
   logic         board_bit, piece_bit;
   logic [23:0]  rgb_nxt;

   assign h_wrap = (h_cnt == H_LAST);
   assign h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
   assign v_nxt  = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_en <= 1'b0;
         h_cnt  <= '0;
         v_cnt  <= '0;
      end else begin
         pix_en <= ~pix_en;
         if (pix_en) begin
            h_cnt <= h_nxt;
            if (h_wrap)
               v_cnt <= v_nxt;
         end
      end
   end

   // Cell indices are tracked by counters keyed off the next position, so they
   // are already correct on the first pixel of each cell without a divider.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_sub <= '0;
         col   <= '0;
         y_sub <= '0;
         row   <= '0;
      end else if (pix_en) begin
         if (h_nxt == PF_X0) begin
            x_sub <= '0;
            col   <= '0;
         end else if (x_sub == SUB_LAST) begin
            x_sub <= '0;
            col   <= col + 4'd1;
         end else begin
            x_sub <= x_sub + 5'd1;
         end
         if (h_wrap) begin
            if (v_nxt == PF_Y0) begin
               y_sub <= '0;
               row   <= '0;
            end else if (y_sub == SUB_LAST) begin
               y_sub <= '0;
               row   <= row + 5'd1;
            end else begin
               y_sub <= y_sub + 5'd1;
            end
         end
      end
   end

   assign snap_evt    = pix_en && (h_cnt == 10'd0) && (v_cnt == V_VIS);
   assign frame_start = snap_evt;
   assign board_ack   = snap_evt && board_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         board_snap <= '0;
         piece_snap <= '0;
      end else if (snap_evt && board_valid) begin
         board_snap <= board_in;
         piece_snap <= piece_in;
      end
   end

   assign in_vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign in_pf  = (h_cnt >= PF_X0) && (h_cnt < PF_X1) && (v_cnt >= PF_Y0) && (v_cnt < PF_Y1);
   assign in_bd  = (h_cnt >= BD_X0) && (h_cnt < BD_X1) && (v_cnt >= BD_Y0) && (v_cnt < BD_Y1);
   assign raw_hs = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
   assign raw_vs = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));

   always_comb begin
      region = RG_OUT;
      if (in_vis) begin
         if (in_pf)
            region = RG_PLAY;
         else if (in_bd)
            region = RG_BORDER;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_region <= RG_OUT;
         s1_col    <= '0;
         s1_row    <= '0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
      end else if (pix_en) begin
         s1_region <= region;
         s1_col    <= col;
         s1_row    <= row;
         s1_hs     <= raw_hs;
         s1_vs     <= raw_vs;
      end
   end

   // Row 0 / col 0 lives in the MSB; the index is parked at 0 off the playfield
   // where row/col hold meaningless values.
   assign cell_lin  = {3'd0, s1_row} * 8'd10 + {4'd0, s1_col};
   assign bit_idx   = (s1_region == RG_PLAY) ? (8'd199 - cell_lin) : 8'd0;
   assign board_bit = board_snap[bit_idx];
   assign piece_bit = piece_snap[bit_idx];

   always_comb begin
      rgb_nxt = 24'h000000;
      if (s1_region == RG_PLAY) begin
         if (piece_bit)
            rgb_nxt = 24'hFF0000;
         else if (board_bit)
            rgb_nxt = 24'h0080FF;
      end else if (s1_region == RG_BORDER) begin
         rgb_nxt = 24'h808080;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         R      <= 8'd0;
         G      <= 8'd0;
         B      <= 8'd0;
         vga_HS <= 1'b1;
         vga_VS <= 1'b1;
      end else if (pix_en) begin
         R      <= rgb_nxt[23:16];
         G      <= rgb_nxt[15:8];
         B      <= rgb_nxt[7:0];
         vga_HS <= s1_hs;
         vga_VS <= s1_vs;
      end
   end

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Directed bench for tetris_vga_renderer: sync timing, snapshot handshake, cell rendering, mid-frame reset.
// Expected times are counted in clk edges since reset release; pixel (x,y) of frame f shows at edge f*840000+2*(800y+x)+4.
module tb_tetris_vga_renderer;

   logic         clk = 1'b0;
   logic         resetn;
   logic [199:0] board_in;
   logic [199:0] piece_in;
   logic         board_valid;
   logic         board_ack;
   logic         frame_start;
   logic         vga_HS;
   logic         vga_VS;
   logic [7:0]   R;
   logic [7:0]   G;
   logic [7:0]   B;

   int unsigned clk_cnt;
   int n_vec = 0;
   int n_err = 0;

   localparam int NPX = 22;
   int unsigned px_x [NPX] = '{220, 220, 215, 218, 219, 220, 240, 239, 220, 100, 650,
                               320, 319, 330, 340, 339, 400, 399, 419, 423, 424, 220};
   int unsigned px_y [NPX] = '{ 35,  36,  40,  40,  40,  40,  40,  59,  60, 100, 100,
                               140, 150, 150, 150, 159, 420, 439, 439, 439, 439, 443};
   logic [23:0] px_c [NPX] = '{24'h000000, 24'h808080, 24'h000000, 24'h808080, 24'h808080,
                               24'h0080FF, 24'h000000, 24'h0080FF, 24'h000000, 24'h000000,
                               24'h000000, 24'hFF0000, 24'h000000, 24'hFF0000, 24'h000000,
                               24'hFF0000, 24'hFF0000, 24'h000000, 24'hFF0000, 24'h808080,
                               24'h000000, 24'h808080};

   tetris_vga_renderer dut (
      .clk         (clk),
      .resetn      (resetn),
      .board_in    (board_in),
      .piece_in    (piece_in),
      .board_valid (board_valid),
      .board_ack   (board_ack),
      .frame_start (frame_start),
      .vga_HS      (vga_HS),
      .vga_VS      (vga_VS),
      .R           (R),
      .G           (G),
      .B           (B)
   );

   always #10 clk = ~clk;

   always @(posedge clk or negedge resetn) begin
      if (!resetn)
         clk_cnt <= 0;
      else
         clk_cnt <= clk_cnt + 1;
   end

   function automatic int unsigned pix_edge(input int unsigned f, input int unsigned x, input int unsigned y);
      return 840000 * f + 2 * (800 * y + x) + 4;
   endfunction

   task automatic goto(input int unsigned e);
      while (clk_cnt < e) @(negedge clk);
   endtask

   task automatic test_reset();
      resetn      = 1'b0;
      board_valid = 1'b1;
      board_in    = '1;
      piece_in    = '1;
      repeat (4) begin
         @(negedge clk);
         n_vec++;
         if ({vga_HS, vga_VS, R, G, B, frame_start, board_ack} !== {2'b11, 24'h000000, 2'b00}) begin
            n_err++;
            $display("FAIL reset_hold: hs=%b vs=%b rgb=%h%h%h fs=%b ack=%b, want hs=1 vs=1 rgb=000000 fs=0 ack=0",
                     vga_HS, vga_VS, R, G, B, frame_start, board_ack);
         end
      end
      board_in    = '0;
      piece_in    = '0;
      board_valid = 1'b0;
      resetn      = 1'b1;
   endtask

   task automatic test_hsync();
      int unsigned e [6] = '{1315, 1316, 1507, 1508, 2915, 2916};
      logic        v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         goto(e[i]);
         n_vec++;
         if (vga_HS !== v[i]) begin
            n_err++;
            $display("FAIL hsync edge %0d: hs=%b want %b", e[i], vga_HS, v[i]);
         end
      end
   endtask

   task automatic test_empty_frame();
      for (int i = 0; i < NPX; i++) begin
         goto(pix_edge(0, px_x[i], px_y[i]));
         n_vec++;
         if ({R, G, B} !== ((px_c[i] == 24'h808080) ? 24'h808080 : 24'h000000)) begin
            n_err++;
            $display("FAIL empty_frame (%0d,%0d): rgb=%h%h%h want %h", px_x[i], px_y[i], R, G, B,
                     (px_c[i] == 24'h808080) ? 24'h808080 : 24'h000000);
         end
      end
   endtask

   task automatic test_snapshot_valid();
      int unsigned e [7] = '{768000, 768001, 768002, 784003, 784004, 787203, 787204};
      logic [3:0]  v [7] = '{4'b0011, 4'b1111, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0011};
      goto(767990);
      board_in      = '0;
      piece_in      = '0;
      board_in[199] = 1'b1;
      board_in[144] = 1'b1;
      piece_in[0]   = 1'b1;
      piece_in[144] = 1'b1;
      board_valid   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         goto(e[i]);
         n_vec++;
         if ({frame_start, board_ack, vga_HS, vga_VS} !== v[i]) begin
            n_err++;
            $display("FAIL snap_valid edge %0d: fs/ack/hs/vs=%b want %b", e[i],
                     {frame_start, board_ack, vga_HS, vga_VS}, v[i]);
         end
      end
   endtask

   task automatic test_midframe_change();
      for (int i = 0; i < NPX; i++) begin
         board_in    = ~board_in;
         board_valid = 1'($urandom_range(0, 1));
         for (int b = 0; b < 200; b++) piece_in[b] = 1'($urandom_range(0, 1));
         goto(pix_edge(1, px_x[i], px_y[i]));
         n_vec++;
         if ({R, G, B} !== px_c[i]) begin
            n_err++;
            $display("FAIL frame1 (%0d,%0d): rgb=%h%h%h want %h", px_x[i], px_y[i], R, G, B, px_c[i]);
         end
      end
   endtask

   task automatic test_no_valid();
      int unsigned e [5] = '{1608000, 1608001, 1608002, 1624003, 1624004};
      logic [3:0]  v [5] = '{4'b0011, 4'b1011, 4'b0011, 4'b0011, 4'b0010};
      board_valid = 1'b0;
      board_in    = '1;
      piece_in    = '1;
      for (int i = 0; i < 5; i++) begin
         goto(e[i]);
         n_vec++;
         if ({frame_start, board_ack, vga_HS, vga_VS} !== v[i]) begin
            n_err++;
            $display("FAIL no_valid edge %0d: fs/ack/hs/vs=%b want %b", e[i],
                     {frame_start, board_ack, vga_HS, vga_VS}, v[i]);
         end
         if (i == 2) board_valid = 1'b1;
      end
      for (int i = 0; i < NPX && px_y[i] < 200; i++) begin
         goto(pix_edge(2, px_x[i], px_y[i]));
         n_vec++;
         if ({R, G, B} !== px_c[i]) begin
            n_err++;
            $display("FAIL frame2 (%0d,%0d): rgb=%h%h%h want %h", px_x[i], px_y[i], R, G, B, px_c[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      goto(pix_edge(2, 700, 200));
      n_vec++;
      if (vga_HS !== 1'b0) begin
         n_err++;
         $display("FAIL pre_reset_hs: hs=%b want 0", vga_HS);
      end
      resetn = 1'b0;
      #1;
      n_vec++;
      if ({vga_HS, vga_VS, R, G, B, frame_start, board_ack} !== {2'b11, 24'h000000, 2'b00}) begin
         n_err++;
         $display("FAIL async_reset: hs=%b vs=%b rgb=%h%h%h fs=%b ack=%b, want 1 1 000000 0 0",
                  vga_HS, vga_VS, R, G, B, frame_start, board_ack);
      end
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if ({vga_HS, vga_VS, R, G, B, frame_start, board_ack} !== {2'b11, 24'h000000, 2'b00}) begin
            n_err++;
            $display("FAIL midreset_hold: hs=%b vs=%b rgb=%h%h%h fs=%b ack=%b, want 1 1 000000 0 0",
                     vga_HS, vga_VS, R, G, B, frame_start, board_ack);
         end
      end
      board_valid = 1'b1;
      board_in    = '1;
      piece_in    = '1;
      resetn      = 1'b1;
      for (int i = 0; i < NPX; i++) begin
         goto(pix_edge(0, px_x[i], px_y[i]));
         n_vec++;
         if ({R, G, B} !== ((px_c[i] == 24'h808080) ? 24'h808080 : 24'h000000)) begin
            n_err++;
            $display("FAIL after_reset (%0d,%0d): rgb=%h%h%h want %h", px_x[i], px_y[i], R, G, B,
                     (px_c[i] == 24'h808080) ? 24'h808080 : 24'h000000);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hsync();
      test_empty_frame();
      test_snapshot_valid();
      test_midframe_change();
      test_no_valid();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
